// File: rtl/lanectrl_pause_gen.sv
// -----------------------------------------------------------------------------
// lanectrl_pause_gen
//
// This is the initiator side of the lane-controller clock-pause interface.
// When a training/calibration update is accepted, the block runs this
// sequence on every lane selected in LANE_MASK:
//   1. Assert HS_IO_CLK_PAUSE.
//   2. Hold it for PRE_CYCLES, so the lane-side synchroniser can settle.
//   3. Strobe DELAY_LOAD for UPD_CYCLES.
//   4. Keep the pause high for another POST_CYCLES.
//   5. Release the pause and pulse UPD_ACK.
// After the ACK, a GAP_CYCLES quiet window is enforced before the block will
// accept another request.
//
// Ports
//   CLK              PHY fabric clock (rising edge)
//   RESET            asynchronous, active-high reset
//   UPD_REQ          level request from the training FSM
//   LANE_MASK        lanes to pause/update; sampled only on acceptance
//   UPD_ACK          one-cycle completion pulse
//   BUSY             high from acceptance until the FSM is back in IDLE
//   HS_IO_CLK_PAUSE  per-lane clock pause (flop output)
//   DELAY_LOAD       per-lane delay-load strobe (flop output)
//   UPD_CNT          count of completed non-empty updates; wraps at 255
// -----------------------------------------------------------------------------
module lanectrl_pause_gen #(
  parameter int NUM_LANES   = 2,
  parameter int PRE_CYCLES  = 4,
  parameter int UPD_CYCLES  = 2,
  parameter int POST_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 UPD_REQ,
  input  logic [NUM_LANES-1:0] LANE_MASK,
  output logic                 UPD_ACK,
  output logic                 BUSY,
  output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
  output logic [NUM_LANES-1:0] DELAY_LOAD,
  output logic [7:0]           UPD_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_LOAD,
    ST_POST,
    ST_GAP
  } state_t;

  // The last value the phase counter reaches in each state.
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYCLES  - 1);
  localparam logic [CNT_W-1:0] UPD_LAST  = CNT_W'(UPD_CYCLES  - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES  - 1);

  state_t               state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [NUM_LANES-1:0] mask_q,    mask_d;
  logic [NUM_LANES-1:0] pause_q,   pause_d;
  logic [NUM_LANES-1:0] load_q,    load_d;
  logic                 ack_q,     ack_d;
  logic                 busy_q,    busy_d;
  logic [7:0]           upd_cnt_q, upd_cnt_d;

  // Next-state logic. The output flops take their next values from the
  // *next* state, so every output is a flop output that lines up with the
  // state it belongs to, and no combinational path reaches the pins.
  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no
    // path through the block can leave a value unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    mask_d    = mask_q;
    ack_d     = 1'b0;
    upd_cnt_d = upd_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (UPD_REQ) begin
          if (|LANE_MASK) begin
            mask_d  = LANE_MASK;
            state_d = ST_PRE;
          end else begin
            // An empty mask gets an immediate ACK. There is no pause and no
            // gap, so a request still held high is accepted again next cycle.
            ack_d = 1'b1;
          end
        end
      end
      ST_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (cnt_q == UPD_LAST) begin
          state_d = ST_POST;
          cnt_d   = '0;
        end
      end
      ST_POST: begin
        if (cnt_q == POST_LAST) begin
          // The ACK cycle is also the first cycle of the gap.
          state_d   = ST_GAP;
          cnt_d     = '0;
          ack_d     = 1'b1;
          upd_cnt_d = upd_cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pause and load both come from the same latched mask, and load is only
    // active inside the pause window. So a lane's DELAY_LOAD can never be high
    // while its HS_IO_CLK_PAUSE is low.
    pause_d = (state_d inside {ST_PRE, ST_LOAD, ST_POST}) ? mask_d : '0;
    load_d  = (state_d == ST_LOAD) ? mask_d : '0;
    busy_d  = (state_d != ST_IDLE);
  end

  // NOTE: every register here is a control flop, so all of them are cleared
  // by the asynchronous reset; a reset mid-sequence drops pause/load at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mask_q    <= '0;
      pause_q   <= '0;
      load_q    <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      upd_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the values from before this edge, whatever the statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      pause_q   <= pause_d;
      load_q    <= load_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      upd_cnt_q <= upd_cnt_d;
    end
  end

  assign HS_IO_CLK_PAUSE = pause_q;
  assign DELAY_LOAD      = load_q;
  assign UPD_ACK         = ack_q;
  assign BUSY            = busy_q;
  assign UPD_CNT         = upd_cnt_q;

endmodule

// File: doc/lanectrl_pause_gen.md
Name: lanectrl_pause_gen

Overview:
- Initiator side of the lane-controller clock-pause interface.
- Turns a training/calibration update request into a bracketed sequence per selected lane:
  - assert HS_IO_CLK_PAUSE,
  - wait for the lane-side pause synchroniser to settle,
  - strobe the delay-load,
  - hold pause through settling,
  - release and acknowledge.
- Sits in the DDR PHY block between the training FSM and the per-lane LANECTRL pause inputs.

Parameters:
- NUM_LANES, 2, number of lane controllers driven.
- PRE_CYCLES, 4, pause-high cycles before DELAY_LOAD; min 1, must be at least the lane synchroniser latency (2) + 1.
- UPD_CYCLES, 2, DELAY_LOAD-high cycles; min 1.
- POST_CYCLES, 4, pause-high cycles after DELAY_LOAD; min 1.
- GAP_CYCLES, 2, minimum pause-low cycles between consecutive sequences, counted from the ACK cycle; min 1.
- CNT_W, 4, phase counter width; must hold max(PRE,UPD,POST,GAP)-1.

Ports:
- CLK  input  1  PHY fabric clock.
- RESET  input  1  reset.
- UPD_REQ  input  1  level request from training FSM.
- LANE_MASK  input  NUM_LANES  lanes to pause/update; sampled only on acceptance.
- UPD_ACK  output  1  one-cycle completion pulse.
- BUSY  output  1  high from acceptance until return to IDLE.
- HS_IO_CLK_PAUSE  output  NUM_LANES  per-lane pause, registered.
- DELAY_LOAD  output  NUM_LANES  per-lane delay-load strobe, registered.
- UPD_CNT  output  8  completed non-empty updates, wrapping.

Behaviour:
- Reset: RESET, asynchronous, active-high; clock CLK; all registers on rising edge.
  - All outputs 0, state IDLE, counter 0, latched mask 0.
  - Reset mid-sequence drops pause/load immediately; no ACK issued; UPD_CNT cleared.
- States: IDLE, PRE, LOAD, POST, GAP. Phase counter loads 0 on each state entry.
- IDLE:
  - UPD_REQ=1 at cycle T0 with LANE_MASK!=0: latch mask; enter PRE. From T1: HS_IO_CLK_PAUSE = mask, BUSY=1.
  - UPD_REQ=1 with LANE_MASK==0: UPD_ACK=1 at T1 only; no pause, BUSY stays 0, UPD_CNT unchanged, stay IDLE.
    - This path does not enforce a gap; REQ still high at T1 is accepted again.
- PRE: PRE_CYCLES cycles (T1..T[PRE]); pause=mask, load=0.
- LOAD: UPD_CYCLES cycles; pause=mask, DELAY_LOAD=mask.
- POST: POST_CYCLES cycles; pause=mask, load=0.
- Cycle after POST:
  - pause=0, UPD_ACK=1 (single cycle), UPD_CNT+1 (255 wraps to 0); enter GAP. This cycle is GAP cycle 1.
- GAP: GAP_CYCLES cycles total, BUSY=1, UPD_REQ ignored; then IDLE with BUSY=0.
- Totals:
  - Pause high for exactly PRE+UPD+POST cycles.
  - ACK at T0+PRE+UPD+POST+1.
  - Next acceptance no earlier than ACK cycle + GAP_CYCLES.
- Handshake:
  - Requester holds UPD_REQ until it sees UPD_ACK, then may drop it.
  - REQ still high in the first IDLE cycle is a new request.
  - REQ deasserted before ACK does not abort the sequence.
- LANE_MASK changes after acceptance are ignored.
- DELAY_LOAD is never high when the corresponding pause bit is low.
- HS_IO_CLK_PAUSE and DELAY_LOAD are driven directly from flops, with no combinational output path.

Test Plan:
- Reset: RESET=1 asynchronously, then release -> all outputs 0, UPD_CNT=0, BUSY=0.
- Defaults, UPD_REQ=1 at T0, LANE_MASK=2'b11, REQ dropped at ACK -> pause=11 T1..T10; DELAY_LOAD=11 T5..T6; UPD_ACK T11 only; BUSY T1..T12; UPD_CNT=1.
- LANE_MASK=2'b01; change to 2'b10 at T3 -> only bit 0 of pause/load toggles, timing as above.
- LANE_MASK=2'b00 at T0 -> UPD_ACK at T1, pause/load stay 0, BUSY 0, UPD_CNT unchanged.
- UPD_REQ held high continuously, mask 2'b11 -> ACKs at T11 and T24; pause low T11..T13; second pause starts T14.
- RESET pulsed at T6 of a sequence -> pause/load 0 immediately, no ACK, UPD_CNT=0; new REQ after release restarts at PRE. Also 256 completed updates -> UPD_CNT wraps to 0.
